gddr6_burst_to_bram_engine: RTL and testbench



---
 rtl/gddr6_burst_to_bram_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_gddr6_burst_to_bram_engine.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gddr6_burst_to_bram_engine.sv
// Multi-beat GDDR6 (NAP AXI4 read) to BRAM mover with a per-lane operation and a 2-stage write pipe.
// Optional build macro GDDR6_BTB_CHECKSUM_EN adds o_checksum (XOR of every word written).
module gddr6_burst_to_bram_engine #(
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned WORD_WIDTH      = 32,
    parameter int unsigned AXI_ADDR_WIDTH  = 28,
    parameter int unsigned BRAM_ADDR_WIDTH = 9,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned AXI_ID          = 0,
    parameter int unsigned ADD_CONST       = 42
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [AXI_ADDR_WIDTH-1:0]  i_src_addr,
    input  logic [BRAM_ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]       i_num_beats,
    input  logic [1:0]                 i_mode,
    input  logic [WORD_WIDTH-1:0]      i_add_value,
    input  logic                       i_abort,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error,
    output logic [LEN_WIDTH-1:0]       o_beats_written,
    output logic                       o_axi_arvalid,
    input  logic                       i_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]  o_axi_araddr,
    output logic [7:0]                 o_axi_arlen,
    output logic [7:0]                 o_axi_arid,
    output logic [2:0]                 o_axi_arsize,
    output logic [1:0]                 o_axi_arburst,
    input  logic                       i_axi_rvalid,
    output logic                       o_axi_rready,
    input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
    input  logic                       i_axi_rlast,
    input  logic [1:0]                 i_axi_rresp,
    input  logic [7:0]                 i_axi_rid,
    output logic                       o_axi_awvalid,
    output logic [AXI_ADDR_WIDTH-1:0]  o_axi_awaddr,
    output logic [7:0]                 o_axi_awlen,
    output logic [7:0]                 o_axi_awid,
    output logic [2:0]                 o_axi_awsize,
    output logic [1:0]                 o_axi_awburst,
    output logic                       o_axi_wvalid,
    output logic [DATA_WIDTH-1:0]      o_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]    o_axi_wstrb,
    output logic                       o_axi_wlast,
    output logic                       o_axi_bready,
`ifdef GDDR6_BTB_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]      o_checksum,
`endif
    output logic                       o_bram_wr_en,
    output logic [BRAM_ADDR_WIDTH-1:0] o_bram_wr_addr,
    output logic [DATA_WIDTH-1:0]      o_bram_wr_data
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned LANES = DATA_WIDTH / WORD_WIDTH;
    localparam logic [7:0]  ID    = 8'(AXI_ID);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(AXI_ADDR_WIDTH'(BYTES - 1));

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e                     state_q;
    logic [AXI_ADDR_WIDTH-1:0]  cur_addr_q;
    logic [LEN_WIDTH-1:0]       remaining_q;
    logic [BRAM_ADDR_WIDTH-1:0] dst_q;
    logic [1:0]                 mode_q;
    logic [WORD_WIDTH-1:0]      add_q;
    logic                       abort_q;
    logic                       drop_q;
    logic [8:0]                 blen_q;
    logic                       s1_valid_q;
    logic [DATA_WIDTH-1:0]      s1_data_q;

    logic [12:0]           bound_beats;
    logic [31:0]           blen_w;
    logic [8:0]            blen_c;
    logic [DATA_WIDTH-1:0] op_data;
    logic [WORD_WIDTH-1:0] lane;
    logic [WORD_WIDTH-1:0] res;
    logic                  beat_hs;
    logic                  beat_bad;

    // Beats left before the next 4 KB page, capped by the request and MAX_BURST.
    always_comb begin
        bound_beats = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFFS;
        blen_w      = 32'(remaining_q);
        if (blen_w > MAX_BURST) blen_w = MAX_BURST;
        if (blen_w > 32'(bound_beats)) blen_w = 32'(bound_beats);
        blen_c      = blen_w[8:0];
    end

    always_comb begin
        op_data = i_axi_rdata;
        lane    = '0;
        res     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = i_axi_rdata[i*WORD_WIDTH +: WORD_WIDTH];
            case (mode_q)
                2'd0:    res = lane;
                2'd1:    res = lane + WORD_WIDTH'(ADD_CONST);
                2'd2:    res = lane + add_q;
                default: res = lane ^ add_q;
            endcase
            op_data[i*WORD_WIDTH +: WORD_WIDTH] = res;
        end
    end

    assign beat_hs  = i_axi_rvalid && o_axi_rready;
    assign beat_bad = (i_axi_rresp != 2'b00) || (i_axi_rid != ID);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q         <= StIdle;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            dst_q           <= '0;
            mode_q          <= '0;
            add_q           <= '0;
            abort_q         <= 1'b0;
            drop_q          <= 1'b0;
            blen_q          <= '0;
            s1_valid_q      <= 1'b0;
            s1_data_q       <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
            o_beats_written <= '0;
            o_axi_arvalid   <= 1'b0;
            o_axi_araddr    <= '0;
            o_axi_arlen     <= '0;
            o_axi_arid      <= '0;
            o_axi_arsize    <= '0;
            o_axi_arburst   <= '0;
            o_axi_rready    <= 1'b0;
            o_bram_wr_en    <= 1'b0;
            o_bram_wr_addr  <= '0;
            o_bram_wr_data  <= '0;
`ifdef GDDR6_BTB_CHECKSUM_EN
            o_checksum      <= '0;
`endif
        end else begin
            s1_valid_q   <= 1'b0;
            o_bram_wr_en <= s1_valid_q;
            if (s1_valid_q) begin
                o_bram_wr_addr  <= dst_q;
                o_bram_wr_data  <= s1_data_q;
                dst_q           <= dst_q + BRAM_ADDR_WIDTH'(1);
                o_beats_written <= o_beats_written + LEN_WIDTH'(1);
`ifdef GDDR6_BTB_CHECKSUM_EN
                o_checksum      <= o_checksum ^ s1_data_q;
`endif
            end
            if (o_busy && i_abort) abort_q <= 1'b1;

            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        cur_addr_q      <= i_src_addr & ADDR_MASK;
                        remaining_q     <= i_num_beats;
                        dst_q           <= i_dst_addr;
                        mode_q          <= i_mode;
                        add_q           <= i_add_value;
                        abort_q         <= 1'b0;
                        drop_q          <= 1'b0;
                        o_error         <= 1'b0;
                        o_beats_written <= '0;
`ifdef GDDR6_BTB_CHECKSUM_EN
                        o_checksum      <= '0;
`endif
                        if (i_num_beats == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_done  <= 1'b0;
                            o_busy  <= 1'b1;
                            state_q <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (!o_axi_arvalid) begin
                        o_axi_arvalid <= 1'b1;
                        o_axi_araddr  <= cur_addr_q;
                        o_axi_arlen   <= 8'(blen_c - 9'd1);
                        o_axi_arid    <= ID;
                        o_axi_arsize  <= 3'(OFFS);
                        o_axi_arburst <= 2'b01;
                        blen_q        <= blen_c;
                    end else if (i_axi_arready) begin
                        o_axi_arvalid <= 1'b0;
                        o_axi_rready  <= 1'b1;
                        state_q       <= StData;
                    end
                end
                StData: begin
                    if (beat_hs) begin
                        // A bad beat poisons the rest of its burst; the burst is still drained.
                        if (beat_bad) begin
                            o_error <= 1'b1;
                            drop_q  <= 1'b1;
                        end else if (!drop_q) begin
                            s1_valid_q <= 1'b1;
                            s1_data_q  <= op_data;
                        end
                        if (i_axi_rlast) begin
                            o_axi_rready <= 1'b0;
                            cur_addr_q   <= cur_addr_q + (AXI_ADDR_WIDTH'(blen_q) << OFFS);
                            remaining_q  <= remaining_q - LEN_WIDTH'(blen_q);
                            if (remaining_q == LEN_WIDTH'(blen_q) || o_error || beat_bad ||
                                abort_q || i_abort) begin
                                state_q <= StDrain;
                            end else begin
                                state_q <= StAddr;
                            end
                        end
                    end
                end
                StDrain: begin
                    // Stage 2 commits on this edge, so only stage 1 must be empty.
                    if (!s1_valid_q) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_axi_awvalid = 1'b0;
    assign o_axi_awaddr  = '0;
    assign o_axi_awlen   = '0;
    assign o_axi_awid    = '0;
    assign o_axi_awsize  = '0;
    assign o_axi_awburst = '0;
    assign o_axi_wvalid  = 1'b0;
    assign o_axi_wdata   = '0;
    assign o_axi_wstrb   = '0;
    assign o_axi_wlast   = 1'b0;
    assign o_axi_bready  = 1'b0;

endmodule

// File: tb/tb_gddr6_burst_to_bram_engine.sv
// Directed bench: AXI read slave model, BRAM write monitor and per-scenario checks.
module tb_gddr6_burst_to_bram_engine;
    localparam int DW = 256;
    localparam int AW = 28;
    localparam int BW = 9;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1, i_start = 1'b0, i_abort = 1'b0;
    logic [AW-1:0] i_src_addr = '0;
    logic [BW-1:0] i_dst_addr = '0;
    logic [LW-1:0] i_num_beats = '0;
    logic [1:0]    i_mode = '0;
    logic [31:0]   i_add_value = '0;
    logic          o_busy, o_done, o_error;
    logic [LW-1:0] o_beats_written;
    logic          o_axi_arvalid, i_axi_arready = 1'b0;
    logic [AW-1:0] o_axi_araddr;
    logic [7:0]    o_axi_arlen, o_axi_arid;
    logic [2:0]    o_axi_arsize;
    logic [1:0]    o_axi_arburst;
    logic          i_axi_rvalid = 1'b0, o_axi_rready, i_axi_rlast = 1'b0;
    logic [DW-1:0] i_axi_rdata = '0;
    logic [1:0]    i_axi_rresp = '0;
    logic [7:0]    i_axi_rid = '0;
    logic          o_axi_awvalid, o_axi_wvalid, o_axi_wlast, o_axi_bready;
    logic [AW-1:0] o_axi_awaddr;
    logic [7:0]    o_axi_awlen, o_axi_awid;
    logic [2:0]    o_axi_awsize;
    logic [1:0]    o_axi_awburst;
    logic [DW-1:0] o_axi_wdata;
    logic [DW/8-1:0] o_axi_wstrb;
    logic          o_bram_wr_en;
    logic [BW-1:0] o_bram_wr_addr;
    logic [DW-1:0] o_bram_wr_data;
`ifdef GDDR6_BTB_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    gddr6_burst_to_bram_engine dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_src_addr(i_src_addr),
        .i_dst_addr(i_dst_addr), .i_num_beats(i_num_beats), .i_mode(i_mode),
        .i_add_value(i_add_value), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_beats_written(o_beats_written), .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(i_axi_arready), .o_axi_araddr(o_axi_araddr), .o_axi_arlen(o_axi_arlen),
        .o_axi_arid(o_axi_arid), .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
        .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready), .i_axi_rdata(i_axi_rdata),
        .i_axi_rlast(i_axi_rlast), .i_axi_rresp(i_axi_rresp), .i_axi_rid(i_axi_rid),
        .o_axi_awvalid(o_axi_awvalid), .o_axi_awaddr(o_axi_awaddr), .o_axi_awlen(o_axi_awlen),
        .o_axi_awid(o_axi_awid), .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
        .o_axi_wvalid(o_axi_wvalid), .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
        .o_axi_wlast(o_axi_wlast), .o_axi_bready(o_axi_bready),
`ifdef GDDR6_BTB_CHECKSUM_EN
        .o_checksum(o_checksum),
`endif
        .o_bram_wr_en(o_bram_wr_en), .o_bram_wr_addr(o_bram_wr_addr),
        .o_bram_wr_data(o_bram_wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int ar_delay = 0, err_beat = -1, rbeat = 0, stable_err = 0;
    bit r_gap = 1'b0, sl_en = 1'b1, arv_seen = 1'b0;
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    logic [BW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            hs_cyc_q[$], wr_cyc_q[$];

    // Memory image: lane j of the beat at byte address a holds (a/32) + (j << 24).
    function automatic logic [DW-1:0] mem_beat(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = 32'(a >> 5) + (32'(j) << 24);
        return d;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int idx, input logic [1:0] m,
                                               input logic [31:0] v);
        logic [DW-1:0] d;
        logic [31:0]   b;
        for (int j = 0; j < DW / 32; j++) begin
            b = 32'(idx) + (32'(j) << 24);
            case (m)
                2'd0:    d[j*32 +: 32] = b;
                2'd1:    d[j*32 +: 32] = b + 32'd42;
                2'd2:    d[j*32 +: 32] = b + v;
                default: d[j*32 +: 32] = b ^ v;
            endcase
        end
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_axi_arvalid) arv_seen = 1'b1;
        if (o_axi_arvalid && i_axi_arready) begin
            ar_addr_q.push_back(o_axi_araddr);
            ar_len_q.push_back(o_axi_arlen);
        end
        if (i_axi_rvalid && o_axi_rready && i_axi_rresp == 2'b00) hs_cyc_q.push_back(cyc);
        if (o_bram_wr_en) begin
            wa_q.push_back(o_bram_wr_addr);
            wd_q.push_back(o_bram_wr_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    always begin : slave
        logic [AW-1:0] a;
        logic [7:0]    l;
        int            w;
        @(posedge clk); #1;
        if (sl_en && o_axi_arvalid) begin
            a = o_axi_araddr;
            l = o_axi_arlen;
            for (int k = 0; k < ar_delay; k++) begin
                @(posedge clk); #1;
                if (o_axi_araddr !== a || o_axi_arlen !== l || o_axi_arvalid !== 1'b1)
                    stable_err++;
            end
            i_axi_arready = 1'b1;
            @(posedge clk); #1;
            i_axi_arready = 1'b0;
            for (int b = 0; b <= int'(l) && sl_en; b++) begin
                if (r_gap && b % 2 == 1) begin @(posedge clk); #1; end
                i_axi_rvalid = 1'b1;
                i_axi_rdata  = mem_beat(a + AW'(b * 32));
                i_axi_rlast  = (b == int'(l));
                i_axi_rresp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
                rbeat++;
                w = 0;
                @(negedge clk);
                while (!o_axi_rready && sl_en && w < 100) begin @(negedge clk); w++; end
                @(posedge clk); #1;
                i_axi_rvalid = 1'b0;
                i_axi_rlast  = 1'b0;
                i_axi_rresp  = 2'b00;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        ar_addr_q.delete(); ar_len_q.delete(); wa_q.delete(); wd_q.delete();
        hs_cyc_q.delete(); wr_cyc_q.delete();
        arv_seen = 1'b0; rbeat = 0; stable_err = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] s, input logic [BW-1:0] d,
                            input logic [LW-1:0] n, input logic [1:0] m, input logic [31:0] v);
        i_src_addr = s; i_dst_addr = d; i_num_beats = n; i_mode = m; i_add_value = v;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (o_done) break;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) tick();
        tests++;
        if ({o_busy, o_done, o_error, o_axi_arvalid, o_axi_rready, o_bram_wr_en} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b want=000000",
                     {o_busy, o_done, o_error, o_axi_arvalid, o_axi_rready, o_bram_wr_en});
        end
        tests++;
        if (o_beats_written !== '0) begin
            fails++; $display("FAIL reset_beats got=%0d want=0", o_beats_written);
        end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_two_bursts();
        logic [DW-1:0] ck;
        ck = '0;
        clear_logs();
        do_start(28'h0, 9'h0, 16'd20, 2'd1, 32'h0);
        repeat (4) tick();
        do_start(28'h4000, 9'h100, 16'd3, 2'd0, 32'h0);  // must be ignored
        wait_done();
        tests++;
        if (ar_addr_q.size() !== 2) begin
            fails++; $display("FAIL tb_ar_count got=%0d want=2", ar_addr_q.size());
        end else begin
            tests++;
            if (ar_addr_q[0] !== 28'h0 || ar_len_q[0] !== 8'd15) begin
                fails++; $display("FAIL tb_ar0 got=%h/%0d want=0/15", ar_addr_q[0], ar_len_q[0]);
            end
            tests++;
            if (ar_addr_q[1] !== 28'h200 || ar_len_q[1] !== 8'd3) begin
                fails++; $display("FAIL tb_ar1 got=%h/%0d want=200/3", ar_addr_q[1], ar_len_q[1]);
            end
        end
        tests++;
        if (wa_q.size() !== 20) begin
            fails++; $display("FAIL tb_wr_count got=%0d want=20", wa_q.size());
        end
        for (int i = 0; i < wa_q.size() && i < 20; i++) begin
            ck = ck ^ exp_beat(i, 2'd1, 32'h0);
            tests++;
            if (wa_q[i] !== BW'(i) || wd_q[i] !== exp_beat(i, 2'd1, 32'h0)) begin
                fails++;
                $display("FAIL tb_wr%0d got=%h/%h want=%h/%h", i, wa_q[i], wd_q[i][31:0],
                         BW'(i), 32'(i + 42));
            end
        end
        tests++;
        if (hs_cyc_q.size() == 0 || wr_cyc_q.size() == 0 || wr_cyc_q[0] - hs_cyc_q[0] != 2) begin
            fails++; $display("FAIL tb_latency got=%0d want=2",
                              (hs_cyc_q.size() > 0 && wr_cyc_q.size() > 0) ?
                              wr_cyc_q[0] - hs_cyc_q[0] : -1);
        end
        tests++;
        if ({o_done, o_error, o_busy} !== 3'b100 || o_beats_written !== 16'd20) begin
            fails++; $display("FAIL tb_status got=%b/%0d want=100/20",
                              {o_done, o_error, o_busy}, o_beats_written);
        end
`ifdef GDDR6_BTB_CHECKSUM_EN
        tests++;
        if (o_checksum !== ck) begin
            fails++; $display("FAIL tb_checksum got=%h want=%h", o_checksum, ck);
        end
`endif
    endtask

    task automatic test_4k_boundary();
        clear_logs();
        do_start(28'hFC0, 9'h10, 16'd4, 2'd2, 32'h100);
        wait_done();
        tests++;
        if (ar_addr_q.size() !== 2 || ar_addr_q[0] !== 28'hFC0 || ar_len_q[0] !== 8'd1 ||
            ar_addr_q[1] !== 28'h1000 || ar_len_q[1] !== 8'd1) begin
            fails++; $display("FAIL k4_ar got_n=%0d want 2 bursts fc0/1 1000/1", ar_addr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (wa_q.size() <= i || wa_q[i] !== BW'(16 + i) ||
                wd_q[i] !== exp_beat(8'h7E + i, 2'd2, 32'h100)) begin
                fails++; $display("FAIL k4_wr%0d want_addr=%h want_lane0=%h", i, 16 + i,
                                  32'h7E + 32'(i) + 32'h100);
            end
        end
    endtask

    task automatic test_error();
        clear_logs();
        err_beat = 2;
        do_start(28'h2000, 9'h0, 16'd20, 2'd3, 32'hFFFF_FFFF);
        wait_done();
        repeat (20) tick();
        err_beat = -1;
        tests++;
        if (wa_q.size() !== 2) begin
            fails++; $display("FAIL err_wr_count got=%0d want=2", wa_q.size());
        end
        for (int i = 0; i < wa_q.size() && i < 2; i++) begin
            tests++;
            if (wd_q[i] !== exp_beat(9'h100 + i, 2'd3, 32'hFFFF_FFFF)) begin
                fails++; $display("FAIL err_wr%0d got=%h want=%h", i, wd_q[i][31:0],
                                  ~(32'h100 + 32'(i)));
            end
        end
        tests++;
        if ({o_done, o_error, o_busy} !== 3'b110 || o_beats_written !== 16'd2) begin
            fails++; $display("FAIL err_status got=%b/%0d want=110/2",
                              {o_done, o_error, o_busy}, o_beats_written);
        end
        tests++;
        if (ar_addr_q.size() !== 1) begin
            fails++; $display("FAIL err_ar_count got=%0d want=1", ar_addr_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [BW-1:0] ea [4];
        ea[0] = 9'h1FE; ea[1] = 9'h1FF; ea[2] = 9'h000; ea[3] = 9'h001;
        clear_logs();
        do_start(28'h100, 9'h1FE, 16'd4, 2'd0, 32'h0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (wa_q.size() <= i || wa_q[i] !== ea[i] || wd_q[i] !== exp_beat(8 + i, 2'd0, 32'h0))
            begin
                fails++; $display("FAIL wrap_wr%0d want_addr=%h want_lane0=%h", i, ea[i], 8 + i);
            end
        end
    endtask

    task automatic test_zero_beats();
        clear_logs();
        do_start(28'h0, 9'h0, 16'd0, 2'd0, 32'h0);
        tests++;
        if ({o_done, o_busy} !== 2'b10 || o_beats_written !== '0) begin
            fails++; $display("FAIL zero_status got=%b/%0d want=10/0", {o_done, o_busy},
                              o_beats_written);
        end
        repeat (10) tick();
        tests++;
        if (arv_seen !== 1'b0) begin
            fails++; $display("FAIL zero_arvalid got=%b want=0", arv_seen);
        end
    endtask

    task automatic test_stall();
        clear_logs();
        ar_delay = 10; r_gap = 1'b1;
        do_start(28'h3000, 9'h40, 16'd6, 2'd1, 32'h0);
        wait_done();
        ar_delay = 0; r_gap = 1'b0;
        tests++;
        if (stable_err !== 0) begin
            fails++; $display("FAIL stall_ar_stable got=%0d want=0", stable_err);
        end
        tests++;
        if (o_beats_written !== 16'd6 || wa_q.size() !== 6) begin
            fails++; $display("FAIL stall_count got=%0d want=6", o_beats_written);
        end
        for (int i = 0; i < wa_q.size() && i < 6; i++) begin
            tests++;
            if (wa_q[i] !== BW'(64 + i) || wd_q[i] !== exp_beat(9'h180 + i, 2'd1, 32'h0)) begin
                fails++; $display("FAIL stall_wr%0d got=%h want_lane0=%h", i, wd_q[i][31:0],
                                  32'h180 + 32'(i) + 32'd42);
            end
        end
    endtask

    task automatic test_abort();
        clear_logs();
        do_start(28'h0, 9'h0, 16'd40, 2'd0, 32'h0);
        repeat (3) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        wait_done();
        repeat (10) tick();
        tests++;
        if ({o_done, o_error} !== 2'b10 || o_beats_written !== 16'd16 || ar_addr_q.size() !== 1)
        begin
            fails++; $display("FAIL abort got=%b/%0d/%0d want=10/16/1", {o_done, o_error},
                              o_beats_written, ar_addr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        do_start(28'h0, 9'h0, 16'd20, 2'd0, 32'h0);
        for (int k = 0; k < 200 && !o_bram_wr_en; k++) tick();
        i_reset = 1'b1; sl_en = 1'b0;
        tick();
        tests++;
        if ({o_busy, o_done, o_error, o_axi_arvalid, o_axi_rready, o_bram_wr_en} !== 6'b0 ||
            o_beats_written !== '0) begin
            fails++; $display("FAIL midreset got=%b/%0d want=000000/0",
                              {o_busy, o_done, o_error, o_axi_arvalid, o_axi_rready, o_bram_wr_en},
                              o_beats_written);
        end
        i_reset = 1'b0;
        repeat (5) tick();
        sl_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_4k_boundary();
        test_error();
        test_wrap();
        test_zero_beats();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
